// File: rtl/seq_div.sv
// Multi-cycle restoring divider: one quotient bit per clock, valid/ready on both sides,
// optional two's-complement operands, remainder and divide-by-zero reporting.
module seq_div #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH:0]   dvs_r;
  logic [WIDTH-1:0] dvd_r;
  logic             q_neg;
  logic             r_neg;

  logic             a_neg, b_neg, b_zero, accept, last_iter, q_bit;
  logic [WIDTH:0]   a_mag, b_mag, shifted, diff, rem_nxt;
  logic [WIDTH-1:0] q_mag, q_res, r_res;
  logic             unused_bits;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);
  assign b_zero    = (b == '0);
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // Magnitudes are formed one bit wider so the most negative operand stays exact.
  always_comb begin
    a_neg = (SIGNED != 0) && a[WIDTH-1];
    b_neg = (SIGNED != 0) && b[WIDTH-1];
    a_mag = a_neg ? (~{1'b1, a} + ONE_X) : {1'b0, a};
    b_mag = b_neg ? (~{1'b1, b} + ONE_X) : {1'b0, b};
  end

  always_comb begin
    shifted = {rem_r[WIDTH-1:0], dvd_r[WIDTH-1]};
    diff    = shifted - dvs_r;
    q_bit   = (shifted >= dvs_r);
    rem_nxt = q_bit ? diff : shifted;
    q_mag   = {dvd_r[WIDTH-2:0], q_bit};
    q_res   = q_neg ? (~q_mag + ONE_W) : q_mag;
    r_res   = r_neg ? (~rem_nxt[WIDTH-1:0] + ONE_W) : rem_nxt[WIDTH-1:0];
  end

  // The remainder never reaches the top bit, and the dividend magnitude fits in WIDTH bits.
  assign unused_bits = ^{a_mag[WIDTH], rem_r[WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = b_zero ? DONE : CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem_r       <= '0;
      dvs_r       <= '0;
      dvd_r       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      rem_r <= '0;
      dvs_r <= b_mag;
      dvd_r <= a_mag[WIDTH-1:0];
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      if (b_zero) begin
        quotient    <= '1;
        remainder   <= a;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      // Quotient bits shift in behind the dividend bits being consumed.
      cnt   <= cnt + CW'(1);
      rem_r <= rem_nxt;
      dvd_r <= q_mag;
      if (last_iter) begin
        quotient    <= q_res;
        remainder   <= r_res;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seq_div.md
# seq_div

Parametrised multi-cycle restoring divider. It computes quotient and remainder one bit per clock and uses a valid/ready handshake on both input and output. It replaces the single-cycle unsigned 32-bit divider in the oscilloscope measurement path, where scaling, period and frequency calculations need width-configurable signed or unsigned division, a remainder, divide-by-zero reporting and backpressure from the consumer.

## Interface
- `WIDTH`, default 32: operand and result width in bits; legal range 2..64.
- `SIGNED`, default 0: 0 selects unsigned division; 1 selects two's-complement truncating division.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: dividend/divisor present.
- `in_ready` out 1: block can accept an operation.
- `a` in WIDTH: dividend, sampled on the accept edge.
- `b` in WIDTH: divisor, sampled on the accept edge.
- `out_valid` out 1: result registers hold a valid result.
- `out_ready` in 1: consumer accepts the result.
- `quotient` out WIDTH: quotient.
- `remainder` out WIDTH: remainder.
- `div_by_zero` out 1: the current result came from `b == 0`.

## Operation
- FSM has three states: IDLE, CALC, DONE. `in_ready = (state == IDLE)`, combinational from state.
- **IDLE:** on `in_valid && in_ready`, register the operands and leave IDLE.
  - If `b == 0`, go to DONE.
  - Otherwise go to CALC with the iteration counter at 0.
  - Inputs are not sampled in any other state.
- **Magnitudes (SIGNED=1):** use |a| and |b| in WIDTH+1-bit arithmetic so that the most negative value is exact. Register the quotient sign as `a[MSB] ^ b[MSB]` and the remainder sign as `a[MSB]`.
- **CALC iteration (one per edge):**
  - Shift {partial remainder, dividend magnitude} left by 1.
  - If partial remainder ≥ divisor magnitude, subtract and set quotient bit 1; else set quotient bit 0.
  - Comparison is ≥, not >.
  - The partial remainder is WIDTH+1 bits wide, so no overflow occurs.
- **End of CALC:** after WIDTH iterations, on the same edge as the last iteration:
  - Load `quotient` and `remainder`, applying the registered signs by two's-complement negation when SIGNED=1.
  - Set `out_valid = 1` and `div_by_zero = 0`, and go to DONE.
- **Divide-by-zero:** on the accept edge, load `quotient` = all ones, `remainder = a` (unmodified), `div_by_zero = 1`, `out_valid = 1`.
- **Signed overflow** (SIGNED=1, a = −2^(WIDTH−1), b = −1): `quotient` = −2^(WIDTH−1) (wraps), `remainder = 0`, `div_by_zero = 0`.
- **DONE:** hold `quotient`, `remainder` and `div_by_zero` stable while `out_valid && !out_ready`. On `out_ready`, clear `out_valid` and go to IDLE.
- After the output handshake, `quotient`, `remainder` and `div_by_zero` keep their last values until the next result load.
- A new operation is accepted no earlier than the cycle after the output handshake (IDLE). No overlap.
- `in_valid` or input changes during CALC/DONE have no effect.

## Timing
- **Reset (rst_n low, immediate):**
  - state = IDLE, so `in_ready = 1`.
  - `out_valid = 0`, `quotient = 0`, `remainder = 0`, `div_by_zero = 0`, counter 0.
  - Inputs are ignored while `rst_n` is low.
- **Reset mid-CALC or mid-DONE:** the operation is aborted with no result produced. The outputs take their reset values immediately.
- **Latency, normal case:** the accept edge is edge 0. `out_valid` is high after edge WIDTH (32 cycles for the default). Latency is independent of operand values and of SIGNED.
- **Latency, divide-by-zero:** `out_valid` is high after edge 0 (1 cycle).
- **Throughput:** with `out_ready` held high, one result per WIDTH+2 cycles.
- **No combinational paths:** `out_ready` does not reach `in_ready` or any output within the same cycle; `in_valid` does not reach any output.

## Test plan
- WIDTH=32, SIGNED=0, a=100, b=7, `out_ready=1` -> `quotient=14`, `remainder=2`, `div_by_zero=0`; `out_valid` rises exactly 32 edges after accept and is high for 1 cycle; `in_ready` is low from edge 0 until the return to IDLE.
- WIDTH=32, SIGNED=0, a=0xFFFFFFFF, b=0xFFFFFFFF, then a=5, b=0 -> first result q=1, r=0; second result q=0xFFFFFFFF, r=5, `div_by_zero=1`, 1-cycle latency.
- WIDTH=16, SIGNED=1, four cases:
  - −7/2 -> q=−3 (0xFFFD), r=−1 (0xFFFF)
  - 7/−2 -> q=−3, r=1
  - −32768/−1 -> q=0x8000, r=0
  - −32768/1 -> q=0x8000, r=0
- Backpressure: hold `out_ready=0` for 10 cycles after `out_valid`, toggling `a`, `b` and `in_valid` meanwhile -> outputs stay constant, `in_ready=0`, and one handshake occurs when `out_ready` rises.
- Reset mid-operation: assert `rst_n=0` at CALC iteration 10 -> `out_valid=0` and `quotient=0` immediately; after release, a fresh 100/7 completes correctly with full latency.
- Randomised unsigned/signed operands at WIDTH=8 (exhaustive over all 65,536 pairs) -> match a reference model, including b=0 and the most-negative cases.
